// File: rtl/bus_burst_arbiter_pkg.sv
// Shared types and width helpers for the burst arbiter (package bus_pkg).
package bus_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter holds 0..BURST_LEN.
  function automatic int beat_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/bus_burst_arbiter_if.sv
// External memory command/data port shared by the arbiter and the memory model.
interface bus_burst_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    input  mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    output mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/bus_burst_arbiter_rr.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] grant,
  output logic          any
);

  logic [CW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = CW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_burst_arbiter.sv
// N-channel burst arbiter between channel FIFOs and one memory port.
// Optional BUS_PINGPONG_EN: per-channel double frame buffers toggled at frame wrap.
module bus_burst_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int LVL_W       = 9,
  parameter int FIFO_DEPTH  = 512,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 76800,
  parameter logic [NUM_CH-1:0] CH_IS_READ = 4'b1100
) (
  input  logic                           ctrl_clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_base,
  input  logic [NUM_CH-1:0][LVL_W-1:0]   ch_level,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_fifo_rd,
  output logic [NUM_CH-1:0]              ch_fifo_wr,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic [NUM_CH-1:0]              ch_frame_done,
  output logic [NUM_CH-1:0]              ch_frame_sel,
  bus_burst_arbiter_if.master            mem,
  output logic                           busy,
  output logic [idx_w(NUM_CH)-1:0]       cur_ch
);

  localparam int CW = idx_w(NUM_CH);
  localparam int BW = beat_w(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);

  state_t                          state;
  logic [CW-1:0]                   gnt, last, pick;
  logic                            any;
  logic [BW-1:0]                   beat;
  logic [NUM_CH-1:0][ADDR_W-1:0]   base_q, off_q, eff_base, eff_off;
  logic [NUM_CH-1:0]               en_q, pend, rise, apply, elig, req, sel_q, eff_sel;
  logic [NUM_CH-1:0]               frame_done;
  logic                            cmd_valid, cmd_we;
  logic [ADDR_W-1:0]               cmd_addr;
  logic                            g_rd, beat_stb, wrap;

  // An enable edge seen while busy is parked in pend and applied back in IDLE.
  always_comb begin
    rise  = ch_en & ~en_q;
    apply = (state == IDLE) ? (rise | pend) : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_base[i] = apply[i] ? ch_base[i] : base_q[i];
      eff_off[i]  = apply[i] ? '0 : off_q[i];
      eff_sel[i]  = apply[i] ? 1'b0 : sel_q[i];
      elig[i]     = ch_en[i] && (CH_IS_READ[i] ?
                    ((FIFO_DEPTH - int'(ch_level[i])) >= BURST_LEN) :
                    (int'(ch_level[i]) >= BURST_LEN));
    end
    req = (state == IDLE) ? elig : '0;
  end

  bus_rr_arbiter #(.N(NUM_CH), .CW(CW)) u_rr (
    .req   (req),
    .last  (last),
    .grant (pick),
    .any   (any)
  );

  assign g_rd     = CH_IS_READ[gnt];
  assign beat_stb = (state == DATA) && (g_rd ? mem.mem_rvalid : mem.mem_wready);
  assign wrap     = (off_q[gnt] + BURST_A) == FRAME_A;

  always_comb begin
    ch_fifo_rd = '0;
    ch_fifo_wr = '0;
    if (state == DATA) begin
      if (g_rd) ch_fifo_wr[gnt] = mem.mem_rvalid;
      else      ch_fifo_rd[gnt] = mem.mem_wready;
    end
  end

  assign mem.mem_wdata     = (state == DATA && !g_rd) ? ch_wdata[gnt] : '0;
  assign ch_rdata          = (state == DATA &&  g_rd) ? mem.mem_rdata : '0;
  assign mem.mem_cmd_valid = cmd_valid;
  assign mem.mem_cmd_we    = cmd_we;
  assign mem.mem_cmd_addr  = cmd_addr;
  assign ch_frame_done     = frame_done;
  assign ch_frame_sel      = sel_q;
  assign busy              = (state != IDLE);
  assign cur_ch            = gnt;

`ifndef BUS_PINGPONG_EN
  assign sel_q = '0;
`endif

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      last       <= CW'(NUM_CH - 1);
      beat       <= '0;
      base_q     <= '0;
      off_q      <= '0;
      en_q       <= '0;
      pend       <= '0;
      frame_done <= '0;
      cmd_valid  <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
`ifdef BUS_PINGPONG_EN
      sel_q      <= '0;
`endif
    end else begin
      en_q       <= ch_en;
      frame_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          base_q[i] <= ch_base[i];
          off_q[i]  <= '0;
          pend[i]   <= 1'b0;
`ifdef BUS_PINGPONG_EN
          sel_q[i]  <= 1'b0;
`endif
        end else if (state != IDLE && rise[i]) begin
          pend[i] <= 1'b1;
        end
      end
      case (state)
        IDLE: if (any) begin
          gnt       <= pick;
          cmd_valid <= 1'b1;
          cmd_we    <= !CH_IS_READ[pick];
          cmd_addr  <= eff_base[pick] + (eff_sel[pick] ? FRAME_A : '0) + eff_off[pick];
          state     <= CMD;
        end
        CMD: if (mem.mem_cmd_ready) begin
          cmd_valid <= 1'b0;
          cmd_we    <= 1'b0;
          cmd_addr  <= '0;
          beat      <= '0;
          state     <= DATA;
        end
        DATA: if (beat_stb) begin
          if (beat == LAST_BEAT) begin
            frame_done[gnt] <= wrap;
            state           <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (wrap) begin
            off_q[gnt] <= '0;
`ifdef BUS_PINGPONG_EN
            sel_q[gnt] <= ~sel_q[gnt];
`endif
          end else begin
            off_q[gnt] <= off_q[gnt] + BURST_A;
          end
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_burst_arbiter.sv
// Randomized bench for bus_burst_arbiter against a per-channel address/round-robin model.
module tb_bus_burst_arbiter;

  localparam int NCH = 4, DW = 32, AW = 24, FW = 1024, BL = 8, DEPTH = 512;
  localparam logic [3:0] IS_RD = 4'b1100;

  logic ctrl_clk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  logic [3:0]        ch_en;
  logic [3:0][23:0]  ch_base;
  logic [3:0][8:0]   ch_level;
  logic [3:0][31:0]  ch_wdata;
  logic [3:0]        ch_fifo_rd, ch_fifo_wr, ch_frame_done, ch_frame_sel;
  logic [31:0]       ch_rdata;
  logic              busy;
  logic [1:0]        cur_ch;

  bus_burst_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  bus_burst_arbiter #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .LVL_W(9), .FIFO_DEPTH(DEPTH),
    .BURST_LEN(BL), .FRAME_WORDS(FW), .CH_IS_READ(IS_RD)
  ) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n), .ch_en(ch_en), .ch_base(ch_base),
    .ch_level(ch_level), .ch_wdata(ch_wdata), .ch_fifo_rd(ch_fifo_rd),
    .ch_fifo_wr(ch_fifo_wr), .ch_rdata(ch_rdata), .ch_frame_done(ch_frame_done),
    .ch_frame_sel(ch_frame_sel), .mem(mem_if), .busy(busy), .cur_ch(cur_ch)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: per-channel frame position and round-robin history.
  logic [23:0] m_base [4];
  int          m_off  [4];
  int          m_sel  [4];
  int          m_last;

  function automatic logic [23:0] m_addr(input int c);
    return m_base[c] + 24'(m_sel[c] * FW) + 24'(m_off[c]);
  endfunction

  function automatic logic [3:0] m_elig();
    logic [3:0] e;
    for (int i = 0; i < 4; i++)
      e[i] = ch_en[i] && (IS_RD[i] ? ((DEPTH - int'(ch_level[i])) >= BL) : (int'(ch_level[i]) >= BL));
    return e;
  endfunction

  function automatic int m_pick(input logic [3:0] e);
    for (int k = 1; k <= 4; k++)
      if (e[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic m_done(input int c, output bit wrap);
    m_off[c] += BL;
    wrap = (m_off[c] == FW);
    if (wrap) begin
      m_off[c] = 0;
`ifdef BUS_PINGPONG_EN
      m_sel[c] = 1 - m_sel[c];
`endif
    end
    m_last = c;
  endtask

  task automatic m_reset();
    m_last = 3;
    for (int i = 0; i < 4; i++) begin
      m_off[i] = 0; m_sel[i] = 0;
      if (ch_en[i]) m_base[i] = ch_base[i];
    end
  endtask

  task automatic set_en(input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i] && !ch_en[i]) begin
        m_base[i] = ch_base[i]; m_off[i] = 0; m_sel[i] = 0;
      end
    ch_en = m;
  endtask

  // Plays the memory side of one burst and reports what the DUT did.
  task automatic run_burst(input int rdy_dly, input bit gaps, input bit last_one,
                           input logic [3:0] drop_mask, output bit got,
                           output logic [23:0] addr, output bit we, output int och,
                           output int nstb, output int nbad, output int nderr,
                           output logic [3:0] fd);
    bit w, r, stb;
    got = 0; addr = '0; we = 0; och = -1; nstb = 0; nbad = 0; nderr = 0; fd = '0;
    mem_if.mem_cmd_ready = 0; mem_if.mem_wready = 0; mem_if.mem_rvalid = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge ctrl_clk);
      if (mem_if.mem_cmd_valid === 1'b1) got = 1;
    end
    if (!got) return;
    addr = mem_if.mem_cmd_addr; we = mem_if.mem_cmd_we; och = int'(cur_ch);
    for (int t = 0; t < rdy_dly; t++) begin
      @(negedge ctrl_clk);
      if (mem_if.mem_cmd_valid !== 1'b1 || mem_if.mem_cmd_addr !== addr || mem_if.mem_cmd_we !== we)
        nbad++;
    end
    mem_if.mem_cmd_ready = 1;
    @(negedge ctrl_clk);
    mem_if.mem_cmd_ready = 0;
    if (last_one)
      for (int i = 0; i < 4; i++) ch_level[i] = IS_RD[i] ? 9'd511 : 9'd0;
    for (int t = 0; t < 400 && nstb < BL; t++) begin
      if (t > 0) @(negedge ctrl_clk);
      w = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      r = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_if.mem_wready = w; mem_if.mem_rvalid = r; mem_if.mem_rdata = $urandom;
      for (int i = 0; i < 4; i++) ch_wdata[i] = $urandom;
      if (nstb == 3) ch_en = ch_en & ~drop_mask;
      #1;
      stb = we ? ch_fifo_rd[och] : ch_fifo_wr[och];
      if (stb !== (we ? w : r)) nbad++;
      if ((ch_fifo_rd | ch_fifo_wr) & ~(4'b1 << och)) nbad++;
      if (stb === 1'b1) begin
        if (we ? (mem_if.mem_wdata !== ch_wdata[och]) : (ch_rdata !== mem_if.mem_rdata)) nderr++;
        nstb++;
      end
    end
    for (int p = 0; p < 3; p++) begin
      @(negedge ctrl_clk);
      mem_if.mem_wready = 1; mem_if.mem_rvalid = 1;
      #1;
      if ((ch_fifo_rd | ch_fifo_wr) !== 4'b0) nbad++;
      if (p == 0) fd = ch_frame_done;
      else if (ch_frame_done !== 4'b0) nbad++;
    end
    mem_if.mem_wready = 0; mem_if.mem_rvalid = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; mem_if.mem_wready = 1; mem_if.mem_rvalid = 1;
    repeat (2) @(negedge ctrl_clk);
    #1;
    n_chk++; if (mem_if.mem_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", mem_if.mem_cmd_valid); end
    n_chk++; if ((ch_fifo_rd | ch_fifo_wr) !== 4'b0) begin n_fail++; $display("FAIL rst_strobes got %b exp 0", ch_fifo_rd | ch_fifo_wr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (cur_ch !== 2'd0) begin n_fail++; $display("FAIL rst_cur_ch got %0d exp 0", cur_ch); end
    n_chk++; if (ch_frame_done !== 4'b0) begin n_fail++; $display("FAIL rst_frame_done got %b exp 0", ch_frame_done); end
    n_chk++; if (ch_frame_sel !== 4'b0) begin n_fail++; $display("FAIL rst_frame_sel got %b exp 0", ch_frame_sel); end
    @(negedge ctrl_clk);
    reset_n = 1; mem_if.mem_wready = 0; mem_if.mem_rvalid = 0;
    m_reset();
    repeat (3) @(negedge ctrl_clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_write();
    bit got, we, wrap; logic [23:0] addr; int c, ns, nb, nd; logic [3:0] fd;
    ch_base[0] = 24'h000100; ch_level[0] = 9'd8;
    set_en(4'b0001);
    for (int b = 0; b < 2; b++) begin
      run_burst(0, 0, b == 1, 4'b0, got, addr, we, c, ns, nb, nd, fd);
      n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL sw_cmd got %b exp 1", got); end
      n_chk++; if (addr !== m_addr(0)) begin n_fail++; $display("FAIL sw_addr got %h exp %h", addr, m_addr(0)); end
      n_chk++; if (we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b exp 1", we); end
      n_chk++; if (c !== 0) begin n_fail++; $display("FAIL sw_ch got %0d exp 0", c); end
      n_chk++; if (ns !== BL) begin n_fail++; $display("FAIL sw_beats got %0d exp %0d", ns, BL); end
      n_chk++; if (nb !== 0) begin n_fail++; $display("FAIL sw_strobe_err got %0d exp 0", nb); end
      n_chk++; if (nd !== 0) begin n_fail++; $display("FAIL sw_wdata_err got %0d exp 0", nd); end
      m_done(0, wrap);
    end
    repeat (5) @(negedge ctrl_clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_quiet got busy %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    bit got, we, wrap; logic [23:0] addr; int c, ns, nb, nd, ec; logic [3:0] fd;
    ch_base[1] = 24'($urandom);
    ch_level[0] = 9'(8 + $urandom_range(0, 100));
    ch_level[1] = 9'(8 + $urandom_range(0, 100));
    set_en(4'b0011);
    for (int b = 0; b < 6; b++) begin
      ec = m_pick(m_elig());
      run_burst($urandom_range(0, 2), 1, b == 5, 4'b0, got, addr, we, c, ns, nb, nd, fd);
      n_chk++; if (c !== ec) begin n_fail++; $display("FAIL rr_grant burst %0d got %0d exp %0d", b, c, ec); end
      n_chk++; if (addr !== m_addr(ec)) begin n_fail++; $display("FAIL rr_addr burst %0d got %h exp %h", b, addr, m_addr(ec)); end
      n_chk++; if (ns !== BL || nb !== 0 || nd !== 0) begin n_fail++; $display("FAIL rr_data burst %0d got beats %0d bad %0d derr %0d exp %0d 0 0", b, ns, nb, nd, BL); end
      m_done(ec, wrap);
    end
  endtask

  task automatic test_read_threshold();
    bit got, we, wrap, seen; logic [23:0] addr; int c, ns, nb, nd; logic [3:0] fd;
    ch_base[2] = 24'($urandom);
    ch_level[2] = 9'd505;
    set_en(4'b0100);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge ctrl_clk);
      if (mem_if.mem_cmd_valid !== 1'b0) seen = 1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rd_free7 got cmd %b exp 0", seen); end
    ch_level[2] = 9'd504;
    run_burst(1, 1, 1, 4'b0, got, addr, we, c, ns, nb, nd, fd);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL rd_cmd got %b exp 1", got); end
    n_chk++; if (we !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b exp 0", we); end
    n_chk++; if (c !== 2) begin n_fail++; $display("FAIL rd_ch got %0d exp 2", c); end
    n_chk++; if (addr !== m_addr(2)) begin n_fail++; $display("FAIL rd_addr got %h exp %h", addr, m_addr(2)); end
    n_chk++; if (ns !== BL || nb !== 0 || nd !== 0) begin n_fail++; $display("FAIL rd_data got beats %0d bad %0d derr %0d exp %0d 0 0", ns, nb, nd, BL); end
    m_done(2, wrap);
  endtask

  task automatic test_stall_disable();
    bit got, we, wrap, seen; logic [23:0] addr; int c, ns, nb, nd; logic [3:0] fd;
    ch_level[0] = 9'd8;
    set_en(4'b0001);
    run_burst(5, 0, 0, 4'b0001, got, addr, we, c, ns, nb, nd, fd);
    n_chk++; if (addr !== m_addr(0)) begin n_fail++; $display("FAIL st_addr got %h exp %h", addr, m_addr(0)); end
    n_chk++; if (nb !== 0) begin n_fail++; $display("FAIL st_stable got %0d errs exp 0", nb); end
    n_chk++; if (ns !== BL) begin n_fail++; $display("FAIL st_beats got %0d exp %0d", ns, BL); end
    m_done(0, wrap);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge ctrl_clk);
      if (mem_if.mem_cmd_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL st_no_regrant got %b exp 0", seen); end
  endtask

  task automatic test_frame();
    bit got, we, wrap; logic [23:0] addr; int c, ns, nb, nd, tot_bad; logic [3:0] fd;
    ch_base[0] = 24'h002000; ch_level[0] = 9'd8;
    set_en(4'b0001);
    tot_bad = 0;
    for (int b = 0; b <= FW / BL; b++) begin
      run_burst(0, 0, b == FW / BL, 4'b0, got, addr, we, c, ns, nb, nd, fd);
      n_chk++; if (addr !== m_addr(0)) begin n_fail++; $display("FAIL fr_addr burst %0d got %h exp %h", b, addr, m_addr(0)); end
      tot_bad += nb + nd + ((ns == BL) ? 0 : 1);
      m_done(0, wrap);
      n_chk++; if (fd !== {3'b0, wrap}) begin n_fail++; $display("FAIL fr_done burst %0d got %b exp %b", b, fd, {3'b0, wrap}); end
      if (wrap) begin
        n_chk++; if (ch_frame_sel[0] !== 1'(m_sel[0])) begin n_fail++; $display("FAIL fr_sel got %b exp %0d", ch_frame_sel[0], m_sel[0]); end
      end
    end
    n_chk++; if (tot_bad !== 0) begin n_fail++; $display("FAIL fr_data got %0d errs exp 0", tot_bad); end
  endtask

  task automatic test_reset_mid();
    bit got, we, wrap; logic [23:0] addr; int c, ns, nb, nd, ec; logic [3:0] fd;
    ch_base[0] = 24'h003000; ch_base[1] = 24'h004000;
    ch_level[0] = 9'd8; ch_level[1] = 9'd8;
    set_en(4'b0011);
    ec = m_pick(m_elig());
    got = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge ctrl_clk);
      if (mem_if.mem_cmd_valid === 1'b1) got = 1;
    end
    n_chk++; if (got !== 1'b1 || int'(cur_ch) !== ec) begin n_fail++; $display("FAIL rm_pre_grant got %b/%0d exp 1/%0d", got, cur_ch, ec); end
    mem_if.mem_cmd_ready = 1;
    @(negedge ctrl_clk);
    mem_if.mem_cmd_ready = 0; mem_if.mem_wready = 1; mem_if.mem_rvalid = 1;
    repeat (3) @(negedge ctrl_clk);
    reset_n = 0;
    #1;
    n_chk++; if ((ch_fifo_rd | ch_fifo_wr) !== 4'b0) begin n_fail++; $display("FAIL rm_strobes got %b exp 0", ch_fifo_rd | ch_fifo_wr); end
    n_chk++; if (busy !== 1'b0 || mem_if.mem_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_abort got busy %b valid %b exp 0 0", busy, mem_if.mem_cmd_valid); end
    @(negedge ctrl_clk);
    reset_n = 1; mem_if.mem_wready = 0; mem_if.mem_rvalid = 0;
    m_reset();
    run_burst(0, 0, 1, 4'b0, got, addr, we, c, ns, nb, nd, fd);
    n_chk++; if (c !== 0) begin n_fail++; $display("FAIL rm_first_ch got %0d exp 0", c); end
    n_chk++; if (addr !== m_addr(0)) begin n_fail++; $display("FAIL rm_addr got %h exp %h", addr, m_addr(0)); end
    n_chk++; if (ns !== BL || nb !== 0) begin n_fail++; $display("FAIL rm_data got beats %0d bad %0d exp %0d 0", ns, nb, BL); end
    m_done(0, wrap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    ch_en = '0; ch_base = '0; ch_level = '0; ch_wdata = '0;
    mem_if.mem_cmd_ready = 0; mem_if.mem_wready = 0;
    mem_if.mem_rvalid = 0; mem_if.mem_rdata = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_threshold();
    test_stall_disable();
    test_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_burst_arbiter.md
Name: bus_burst_arbiter

Overview:
- N-channel burst arbiter between per-channel clock-crossing FIFOs and one external memory command/data port, all on ctrl_clk.
- Parametrised successor to the single camera-write/display-read frame bus.
- Channels are marked write (camera FIFO → memory) or read (memory → display FIFO).
- Each channel gets a linear frame address counter, round-robin grants and a frame-done pulse.

Parameters:
- NUM_CH, 4: channel count (2..8).
- DATA_W, 32: data word width.
- ADDR_W, 24: word address width.
- LVL_W, 9: FIFO usedw width.
- FIFO_DEPTH, 512: per-channel FIFO depth in words.
- BURST_LEN, 8: words per burst; FRAME_WORDS must be a multiple of it.
- FRAME_WORDS, 76800: words per frame (320x240).
- CH_IS_READ, 4'b1100: bit i set → channel i is a read channel.

Ports:
- ctrl_clk, in, 1: sole clock.
- reset_n, in, 1: asynchronous active-low reset.
- ch_en, in, NUM_CH: per-channel enable.
- ch_base, in, NUM_CH x ADDR_W: frame base word address, latched on ch_en rising.
- ch_level, in, NUM_CH x LVL_W: write ch = rdusedw of its FIFO; read ch = wrusedw of its FIFO.
- ch_wdata, in, NUM_CH x DATA_W: show-ahead head word of each write FIFO.
- ch_fifo_rd, out, NUM_CH: pop strobe to write FIFOs.
- ch_fifo_wr, out, NUM_CH: push strobe to read FIFOs.
- ch_rdata, out, DATA_W: memory read data, broadcast to all read FIFOs.
- ch_frame_done, out, NUM_CH: 1-cycle pulse when a channel wraps its frame.
- ch_frame_sel, out, NUM_CH: active buffer index per channel.
- mem_cmd_valid, out, 1: command request.
- mem_cmd_ready, in, 1: command accepted.
- mem_cmd_we, out, 1: 1 = write burst.
- mem_cmd_addr, out, ADDR_W: burst start word address.
- mem_wdata, out, DATA_W: write data.
- mem_wready, in, 1: memory consumes mem_wdata this cycle.
- mem_rdata, in, DATA_W: read data.
- mem_rvalid, in, 1: mem_rdata valid.
- busy, out, 1: FSM not in IDLE.
- cur_ch, out, $clog2(NUM_CH): granted channel index.

Behaviour:
- Reset (async): all outputs 0; FSM = IDLE; offsets 0; frame_sel 0; round-robin last-grant = NUM_CH-1, so ch0 wins first.
- Eligibility, evaluated in IDLE:
  - write ch: ch_en && ch_level >= BURST_LEN.
  - read ch: ch_en && (FIFO_DEPTH - ch_level) >= BURST_LEN.
- FSM IDLE:
  - If any channel is eligible, grant the first eligible index searching (last+1) mod NUM_CH upward.
  - Register grant into cur_ch and go to CMD.
  - cmd_valid rises the cycle after eligibility is seen.
- FSM CMD:
  - Drive mem_cmd_valid=1, mem_cmd_we=!CH_IS_READ[g], mem_cmd_addr = base_g + sel_g*FRAME_WORDS + offset_g.
  - Hold all three stable until mem_cmd_ready; on the ready cycle go to DATA and clear the beat counter.
- FSM DATA, write channel:
  - mem_wdata = ch_wdata[g].
  - ch_fifo_rd[g] = mem_wready, same cycle; count one beat per mem_wready.
- FSM DATA, read channel:
  - ch_rdata = mem_rdata; ch_fifo_wr[g] = mem_rvalid; count one beat per mem_rvalid.
- Burst end:
  - On the BURST_LEN-th beat go to DONE.
- FSM DONE, 1 cycle:
  - offset_g += BURST_LEN.
  - If the result equals FRAME_WORDS: offset_g = 0, pulse ch_frame_done[g], toggle sel_g (feature only).
  - Update last-grant = g; return to IDLE.
  - Minimum 4-cycle gap between command issues.
- Strobes: only channel g's strobe may be asserted; all others stay 0.
- ch_en deasserted mid-burst: the burst completes normally; the channel is then ineligible.
- ch_en rising edge: in IDLE, latch ch_base and clear offset/sel; while busy, apply the same on return to IDLE.
- Simultaneous wready/rvalid on a wrong-direction channel: ignored.
- Stray mem_wready/mem_rvalid outside DATA: ignored.
- Reset mid-burst: FSM aborts; no strobes are issued after reset.

Optional Feature:
- Macro BUS_PINGPONG_EN.
- Defined: each channel alternates between two frame buffers at base and base+FRAME_WORDS; sel_g toggles at each frame wrap; ch_frame_sel reflects sel_g.
- Undefined: sel_g is constant 0, ch_frame_sel is tied 0, and addresses never exceed base+FRAME_WORDS-1.

Decomposition:
- Package bus_pkg holds:
  - state enum (IDLE, CMD, DATA, DONE)
  - beat counter width $clog2(BURST_LEN+1)
  - function for index width
- Sub-module bus_rr_arbiter: combinational round-robin picker (req vector, last index → grant index, any-valid).

Test Plan:
- Single write ch0, level 8, wready always 1:
  - addr = base 0x000100; exactly 8 ch_fifo_rd[0] pulses; mem_wdata tracks ch_wdata[0]; offset becomes 8.
- ch0 and ch1 write, both level >= 8, continuously:
  - grants go 0,1,0,1; cur_ch alternates; no back-to-back same-channel grant while the other is eligible.
- Read ch2, level 505 (free 7) → no command; level 504 → command with we=0.
  - Then 8 mem_rvalid (with gaps) → 8 ch_fifo_wr[2] pulses.
- ch0 run to a full frame of 9600 bursts:
  - ch_frame_done[0] pulses once, in the DONE cycle of burst 9600; next addr = base.
  - With BUS_PINGPONG_EN, next addr = base+76800 and ch_frame_sel[0]=1.
- mem_cmd_ready held low 5 cycles: addr/we/valid stable.
  - Then ch_en[0] dropped mid-DATA: burst finishes all 8 beats, then no new grant.
- reset_n asserted mid-DATA:
  - all strobes 0 immediately; after release, first grant goes to ch0 at offset 0.
